match_controller: RTL and testbench

//  Sequences a best-of-N fighting match around the LeftPlayer/RightPlayer datapaths.
//  - Filters raw player commands, then issues them to both datapaths on a periodic game step.
//  - Resets the datapaths at the start of each round, watches both healths for KO,

---
 rtl/match_controller_pkg.sv | 34 +++
 rtl/match_controller_if.sv | 39 +++
 rtl/match_controller_step_ticker.sv | 29 ++
 rtl/match_controller.sv | 207 ++++++++++++++++++++
 tb/tb_match_controller.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/match_controller_pkg.sv
// Shared types and constants for the fighting-match controller.
package match_controller_pkg;

  typedef logic [5:0] cmd_t;

  // One-hot command encoding {R,L,WAIT,JUMP,KICK,PUNCH}
  localparam cmd_t CMD_R     = 6'b100000;
  localparam cmd_t CMD_L     = 6'b010000;
  localparam cmd_t CMD_WAIT  = 6'b001000;
  localparam cmd_t CMD_JUMP  = 6'b000100;
  localparam cmd_t CMD_KICK  = 6'b000010;
  localparam cmd_t CMD_PUNCH = 6'b000001;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_ROUND_END  = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_e;

  // A command is only legal when exactly one bit is set
  function automatic logic is_onehot(input cmd_t c);
    return (c != 6'd0) && ((c & (c - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Bundle of player commands/healths in and datapath controls/status out.
interface match_controller_if;
  import match_controller_pkg::*;

  logic       i_start;
  cmd_t       i_left_cmd;
  cmd_t       i_right_cmd;
  logic [1:0] i_left_health;
  logic [1:0] i_right_health;

  cmd_t       o_left_cmd_out;
  cmd_t       o_right_cmd_out;
  logic       o_step;
  logic       o_players_rst;
  logic [2:0] o_state;
  logic [5:0] o_round_timer;
  logic [2:0] o_round_num;
  logic [1:0] o_left_wins;
  logic [1:0] o_right_wins;
  logic [1:0] o_winner;
  logic       o_match_over;

  // Environment side: drives player inputs, observes controller outputs
  modport master (
    output i_start, i_left_cmd, i_right_cmd, i_left_health, i_right_health,
    input  o_left_cmd_out, o_right_cmd_out, o_step, o_players_rst, o_state,
           o_round_timer, o_round_num, o_left_wins, o_right_wins, o_winner,
           o_match_over
  );

  // Controller side
  modport slave (
    input  i_start, i_left_cmd, i_right_cmd, i_left_health, i_right_health,
    output o_left_cmd_out, o_right_cmd_out, o_step, o_players_rst, o_state,
           o_round_timer, o_round_num, o_left_wins, o_right_wins, o_winner,
           o_match_over
  );

endinterface

// File: rtl/match_controller_step_ticker.sv
// Game-step divider: tick is high on the last count of each TICK_DIV window.
module match_controller_step_ticker #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count modulo TICK_DIV, restarting at zero whenever the FSM changes phase
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer: countdown, fight steps, round scoring, match result.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int TICK_DIV        = 4,
  parameter int ROUND_STEPS     = 60,
  parameter int COUNTDOWN_STEPS = 3,
  parameter int WINS_TO_MATCH   = 2,
  parameter int MAX_ROUNDS      = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  match_controller_if.slave bus
);

  localparam logic [3:0] CD_LAST  = 4'(COUNTDOWN_STEPS - 1);
  localparam logic [5:0] T_FULL   = 6'(ROUND_STEPS);
  localparam logic [1:0] W_TARGET = 2'(WINS_TO_MATCH);
  localparam logic [2:0] R_MAX    = 3'(MAX_ROUNDS);

  state_e     r_state, w_state_next;
  logic       w_tick, w_clr;
  logic [3:0] r_cd_cnt;
  logic       w_round_end, w_decided, w_enter_cd, w_fight_step;
  winner_e    w_round_res, w_final_winner;
  cmd_t       w_left_next, w_right_next;

  cmd_t       r_left_cmd_out, r_right_cmd_out, r_left_latch, r_right_latch;
  logic       r_step, r_players_rst, r_match_over;
  logic [5:0] r_round_timer;
  logic [2:0] r_round_num;
  logic [1:0] r_left_wins, r_right_wins;
  winner_e    r_winner;

  match_controller_step_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Round outcome (KO before timeout) and whether the match is already decided
  always_comb begin
    w_round_end = 1'b0;
    w_round_res = WIN_NONE;
    if (r_state == ST_FIGHT) begin
      if ((bus.i_left_health == 2'd0) && (bus.i_right_health == 2'd0)) begin
        w_round_end = 1'b1;
        w_round_res = WIN_DRAW;
      end else if (bus.i_left_health == 2'd0) begin
        w_round_end = 1'b1;
        w_round_res = WIN_RIGHT;
      end else if (bus.i_right_health == 2'd0) begin
        w_round_end = 1'b1;
        w_round_res = WIN_LEFT;
      end else if (r_round_timer == 6'd0) begin
        w_round_end = 1'b1;
        if (bus.i_left_health > bus.i_right_health) begin
          w_round_res = WIN_LEFT;
        end else if (bus.i_right_health > bus.i_left_health) begin
          w_round_res = WIN_RIGHT;
        end else begin
          w_round_res = WIN_DRAW;
        end
      end else begin
        w_round_end = 1'b0;
      end
    end else begin
      w_round_end = 1'b0;
    end
    w_decided = (r_left_wins == W_TARGET) || (r_right_wins == W_TARGET) ||
                (r_round_num == R_MAX);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) w_state_next = ST_COUNTDOWN;
        else             w_state_next = ST_IDLE;
      end
      ST_COUNTDOWN: begin
        if (w_tick && (r_cd_cnt == CD_LAST)) w_state_next = ST_FIGHT;
        else                                 w_state_next = ST_COUNTDOWN;
      end
      ST_FIGHT: begin
        if (w_round_end) w_state_next = ST_ROUND_END;
        else             w_state_next = ST_FIGHT;
      end
      ST_ROUND_END: begin
        if (w_tick && w_decided) w_state_next = ST_MATCH_OVER;
        else if (w_tick)         w_state_next = ST_COUNTDOWN;
        else                     w_state_next = ST_ROUND_END;
      end
      ST_MATCH_OVER: begin
        if (bus.i_start) w_state_next = ST_COUNTDOWN;
        else             w_state_next = ST_MATCH_OVER;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output/control decode feeding the registered outputs
  always_comb begin
    w_clr        = (w_state_next != r_state);
    w_enter_cd   = (w_state_next == ST_COUNTDOWN) && (r_state != ST_COUNTDOWN);
    w_fight_step = (r_state == ST_FIGHT) && !w_round_end && w_tick;
    w_left_next  = is_onehot(bus.i_left_cmd)  ? bus.i_left_cmd  : r_left_latch;
    w_right_next = is_onehot(bus.i_right_cmd) ? bus.i_right_cmd : r_right_latch;
    if (r_left_wins == W_TARGET)          w_final_winner = WIN_LEFT;
    else if (r_right_wins == W_TARGET)    w_final_winner = WIN_RIGHT;
    else if (r_left_wins > r_right_wins)  w_final_winner = WIN_LEFT;
    else if (r_right_wins > r_left_wins)  w_final_winner = WIN_RIGHT;
    else                                  w_final_winner = WIN_DRAW;
  end

  // Round bookkeeping: pulses, countdown progress, timer, round and win counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_players_rst <= 1'b0;
      r_step        <= 1'b0;
      r_match_over  <= 1'b0;
      r_cd_cnt      <= 4'd0;
      r_round_timer <= T_FULL;
      r_round_num   <= 3'd0;
      r_left_wins   <= 2'd0;
      r_right_wins  <= 2'd0;
      r_winner      <= WIN_NONE;
    end else begin
      r_players_rst <= w_enter_cd;
      r_step        <= w_fight_step;
      r_match_over  <= (w_state_next == ST_MATCH_OVER);
      if (w_enter_cd) begin
        r_cd_cnt <= 4'd0;
      end else if ((r_state == ST_COUNTDOWN) && w_tick) begin
        r_cd_cnt <= r_cd_cnt + 4'd1;
      end
      if (w_enter_cd) begin
        r_round_timer <= T_FULL;
        // A restart from MATCH_OVER clears the match before counting round one
        r_round_num   <= (r_state == ST_MATCH_OVER) ? 3'd1 : r_round_num + 3'd1;
      end else if (w_fight_step && (r_round_timer != 6'd0)) begin
        r_round_timer <= r_round_timer - 6'd1;
      end
      if (w_enter_cd && (r_state == ST_MATCH_OVER)) begin
        r_left_wins  <= 2'd0;
        r_right_wins <= 2'd0;
        r_winner     <= WIN_NONE;
      end else if (w_round_end) begin
        if ((w_round_res == WIN_LEFT) && (r_left_wins != W_TARGET))
          r_left_wins <= r_left_wins + 2'd1;
        if ((w_round_res == WIN_RIGHT) && (r_right_wins != W_TARGET))
          r_right_wins <= r_right_wins + 2'd1;
      end else if ((r_state == ST_ROUND_END) && (w_state_next == ST_MATCH_OVER)) begin
        r_winner <= w_final_winner;
      end
    end
  end

  // Command filter: latch last legal command, publish it on each game step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_left_cmd_out  <= CMD_WAIT;
      r_right_cmd_out <= CMD_WAIT;
      r_left_latch    <= CMD_WAIT;
      r_right_latch   <= CMD_WAIT;
    end else if ((r_state == ST_FIGHT) && !w_round_end) begin
      if (w_tick) begin
        r_left_cmd_out  <= w_left_next;
        r_right_cmd_out <= w_right_next;
        r_left_latch    <= CMD_WAIT;
        r_right_latch   <= CMD_WAIT;
      end else begin
        r_left_latch    <= w_left_next;
        r_right_latch   <= w_right_next;
      end
    end else begin
      r_left_cmd_out  <= CMD_WAIT;
      r_right_cmd_out <= CMD_WAIT;
      r_left_latch    <= CMD_WAIT;
      r_right_latch   <= CMD_WAIT;
    end
  end

  assign bus.o_left_cmd_out  = r_left_cmd_out;
  assign bus.o_right_cmd_out = r_right_cmd_out;
  assign bus.o_step          = r_step;
  assign bus.o_players_rst   = r_players_rst;
  assign bus.o_state         = r_state;
  assign bus.o_round_timer   = r_round_timer;
  assign bus.o_round_num     = r_round_num;
  assign bus.o_left_wins     = r_left_wins;
  assign bus.o_right_wins    = r_right_wins;
  assign bus.o_winner        = r_winner;
  assign bus.o_match_over    = r_match_over;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with default parameters.
module tb_match_controller;
  import match_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;

  match_controller_if bus();

  match_controller dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    cmd_t l0, l1, r0, r1;
    cmd_t exp_l, exp_r;
  } vec_t;

  vec_t vecs[5];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output int cnt);
    cnt = 0;
    while ((bus.o_state != st) && (cnt < budget)) begin
      cyc();
      cnt++;
    end
    n_tests++;
    if (bus.o_state != st) begin
      n_fail++;
      $display("FAIL wait_state: got state %0d expected %0d within %0d cycles",
               bus.o_state, st, budget);
    end
  endtask

  task automatic wait_step(input int budget, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!bus.o_step && (cnt < budget));
    n_tests++;
    if (!bus.o_step) begin
      n_fail++;
      $display("FAIL wait_step: no step within %0d cycles", budget);
    end
  endtask

  initial begin
    vecs[0] = '{l0: CMD_KICK,  l1: CMD_JUMP,   r0: CMD_R,      r1: 6'b000000, exp_l: CMD_JUMP,  exp_r: CMD_R};
    vecs[1] = '{l0: CMD_L,     l1: 6'b110000,  r0: 6'b000000,  r1: 6'b000000, exp_l: CMD_L,     exp_r: CMD_WAIT};
    vecs[2] = '{l0: 6'b000000, l1: 6'b000000,  r0: CMD_PUNCH,  r1: 6'b111111, exp_l: CMD_WAIT,  exp_r: CMD_PUNCH};
    vecs[3] = '{l0: CMD_WAIT,  l1: 6'b000000,  r0: 6'b000101,  r1: CMD_KICK,  exp_l: CMD_WAIT,  exp_r: CMD_KICK};
    vecs[4] = '{l0: CMD_R,     l1: CMD_R,      r0: CMD_JUMP,   r1: CMD_L,     exp_l: CMD_R,     exp_r: CMD_L};

    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_left_cmd = 6'd0;
    bus.i_right_cmd = 6'd0;
    bus.i_left_health = 2'd3;
    bus.i_right_health = 2'd3;
    repeat (3) cyc();

    // 1) reset values, start, countdown length, first step
    check("rst_state", int'(bus.o_state), 0);
    check("rst_lcmd", int'(bus.o_left_cmd_out), int'(CMD_WAIT));
    check("rst_rcmd", int'(bus.o_right_cmd_out), int'(CMD_WAIT));
    check("rst_timer", int'(bus.o_round_timer), 60);
    check("rst_round", int'(bus.o_round_num), 0);
    check("rst_wins", int'({bus.o_left_wins, bus.o_right_wins}), 0);
    check("rst_winner", int'(bus.o_winner), 0);
    check("rst_pulses", int'({bus.o_step, bus.o_players_rst, bus.o_match_over}), 0);
    rst = 1'b0;
    cyc();
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    check("cd_state", int'(bus.o_state), 1);
    check("cd_prst", int'(bus.o_players_rst), 1);
    check("cd_round", int'(bus.o_round_num), 1);
    cyc();
    check("cd_prst_once", int'(bus.o_players_rst), 0);
    wait_state(3'd2, 20, n);
    check("cd_len", n + 1, 12);
    wait_step(10, n);
    check("first_step", n, 4);
    check("timer_dec", int'(bus.o_round_timer), 59);

    // 2) command filter: last legal wins, illegal ignored, WAIT when idle
    bus.i_left_cmd = CMD_PUNCH;
    cyc();
    bus.i_left_cmd = 6'b000011;
    cyc();
    bus.i_left_cmd = 6'd0;
    cyc();
    cyc();
    check("step2", int'(bus.o_step), 1);
    check("punch_out", int'(bus.o_left_cmd_out), int'(CMD_PUNCH));
    check("right_wait", int'(bus.o_right_cmd_out), int'(CMD_WAIT));
    cyc();
    check("held_out", int'(bus.o_left_cmd_out), int'(CMD_PUNCH));
    check("step_strobe", int'(bus.o_step), 0);
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    check("start_ign_st", int'(bus.o_state), 2);
    check("start_ign_rn", int'(bus.o_round_num), 1);
    cyc();
    cyc();
    check("step3", int'(bus.o_step), 1);
    check("idle_wait", int'(bus.o_left_cmd_out), int'(CMD_WAIT));

    for (int i = 0; i < 5; i++) begin
      bus.i_left_cmd = vecs[i].l0;
      bus.i_right_cmd = vecs[i].r0;
      cyc();
      cyc();
      bus.i_left_cmd = vecs[i].l1;
      bus.i_right_cmd = vecs[i].r1;
      cyc();
      cyc();
      check($sformatf("vec%0d_step", i), int'(bus.o_step), 1);
      check($sformatf("vec%0d_l", i), int'(bus.o_left_cmd_out), int'(vecs[i].exp_l));
      check($sformatf("vec%0d_r", i), int'(bus.o_right_cmd_out), int'(vecs[i].exp_r));
    end
    bus.i_left_cmd = 6'd0;
    bus.i_right_cmd = 6'd0;

    // 3) KO on a tick cycle suppresses the step; second KO ends the match
    cyc();
    cyc();
    cyc();
    bus.i_right_health = 2'd0;
    cyc();
    check("ko_state", int'(bus.o_state), 3);
    check("ko_nostep", int'(bus.o_step), 0);
    check("ko_lwins", int'(bus.o_left_wins), 1);
    check("ko_winner0", int'(bus.o_winner), 0);
    bus.i_right_health = 2'd3;
    wait_state(3'd1, 10, n);
    check("re_len", n, 4);
    check("re_prst", int'(bus.o_players_rst), 1);
    check("re_round", int'(bus.o_round_num), 2);
    wait_state(3'd2, 20, n);
    bus.i_right_health = 2'd0;
    cyc();
    check("ko2_lwins", int'(bus.o_left_wins), 2);
    bus.i_right_health = 2'd3;
    wait_state(3'd4, 10, n);
    check("mo_len", n, 4);
    check("mo_winner", int'(bus.o_winner), 1);
    check("mo_flag", int'(bus.o_match_over), 1);
    repeat (3) cyc();
    check("mo_hold", int'({bus.o_state, bus.o_winner}), 17);

    // 4) restart; timeout 3/2 -> left; 2/2 -> draw
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    check("rs_round", int'(bus.o_round_num), 1);
    check("rs_clear", int'({bus.o_left_wins, bus.o_right_wins, bus.o_winner, bus.o_match_over}), 0);
    bus.i_left_health = 2'd3;
    bus.i_right_health = 2'd2;
    wait_state(3'd2, 20, n);
    wait_state(3'd3, 300, n);
    check("to_len", n, 241);
    check("to_timer", int'(bus.o_round_timer), 0);
    check("to_wins", int'({bus.o_left_wins, bus.o_right_wins}), 4);
    bus.i_left_health = 2'd2;
    wait_state(3'd2, 40, n);
    wait_state(3'd3, 300, n);
    check("dr_len", n, 241);
    check("dr_wins", int'({bus.o_left_wins, bus.o_right_wins}), 4);
    check("dr_round", int'(bus.o_round_num), 2);
    bus.i_left_health = 2'd3;
    bus.i_right_health = 2'd3;
    wait_state(3'd2, 40, n);
    bus.i_left_health = 2'd0;
    cyc();
    check("r3_rwins", int'(bus.o_right_wins), 1);

    // 6) double KO on the timeout cycle is a draw; rst mid-FIGHT
    bus.i_left_health = 2'd3;
    bus.i_right_health = 2'd1;
    wait_state(3'd2, 40, n);
    n = 0;
    while ((bus.o_round_timer != 6'd0) && (n < 300)) begin
      cyc();
      n++;
    end
    check("r4_timer0", int'(bus.o_round_timer), 0);
    bus.i_left_health = 2'd0;
    bus.i_right_health = 2'd0;
    cyc();
    check("dko_state", int'(bus.o_state), 3);
    check("dko_wins", int'({bus.o_left_wins, bus.o_right_wins}), 5);
    check("dko_round", int'(bus.o_round_num), 4);
    bus.i_left_health = 2'd3;
    bus.i_right_health = 2'd3;
    wait_state(3'd2, 40, n);
    bus.i_left_cmd = CMD_KICK;
    wait_step(10, n);
    check("pre_rst_kick", int'(bus.o_left_cmd_out), int'(CMD_KICK));
    bus.i_left_cmd = 6'd0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_state", int'(bus.o_state), 0);
    check("mid_rst_cmds", int'({bus.o_left_cmd_out, bus.o_right_cmd_out}), int'({CMD_WAIT, CMD_WAIT}));
    check("mid_rst_cnt", int'({bus.o_round_num, bus.o_left_wins, bus.o_right_wins}), 0);
    check("mid_rst_timer", int'(bus.o_round_timer), 60);
    check("mid_rst_prst", int'(bus.o_players_rst), 0);
    cyc();
    check("post_rst_prst", int'(bus.o_players_rst), 0);

    // 5) five draws -> MATCH_OVER with winner 11
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      wait_state(3'd2, 40, n);
      bus.i_left_health = 2'd0;
      bus.i_right_health = 2'd0;
      cyc();
      check($sformatf("draw%0d_state", r), int'(bus.o_state), 3);
      check($sformatf("draw%0d_round", r), int'(bus.o_round_num), r);
      check($sformatf("draw%0d_wins", r), int'({bus.o_left_wins, bus.o_right_wins}), 0);
      bus.i_left_health = 2'd3;
      bus.i_right_health = 2'd3;
    end
    wait_state(3'd4, 10, n);
    check("draws_winner", int'(bus.o_winner), 3);
    check("draws_round", int'(bus.o_round_num), 5);
    check("draws_flag", int'(bus.o_match_over), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
